vga_pixel_scan: RTL and testbench

Scan-timing and image-address generator for the VGA output path. It produces the 640x480@60 Hz raster coordinates, sync and blanking signals, and the 25 MHz pixel strobe from the 50 MHz system clock. It also generates the read address into the 100x100 8-bit image RAM. The `x`/`y` outputs and the RAM's `ReadData` feed the graphics stage directly, and the sync/blank outputs go to the DAC pins.

---
 rtl/vga_pixel_scan.sv | 110 +++++++++++
 tb/tb_vga_pixel_scan.sv | 129 ++++++++++++
 2 files changed

// File: rtl/vga_pixel_scan.sv
// 640x480@60 raster timing, sync/blank and image-RAM address generator, pixel strobe at clk/2.
// Outputs are registered from next-state counters and change together once per pixel (every 2 clk).
// Free-running source with no backpressure; the DAC and RAM consume every pixel unconditionally.
module vga_pixel_scan #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int IMG_W    = 100,
    parameter int IMG_H    = 100,
    parameter int ADDR_W   = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [9:0]        x,
    output logic [9:0]        y,
    output logic [ADDR_W-1:0] addr,
    output logic              hsync,
    output logic              vsync,
    output logic              blank_n,
    output logic              sync_n,
    output logic              vga_clk,
    output logic              frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] IMG_W_C  = 10'(IMG_W);
    localparam logic [9:0] IMG_H_C  = 10'(IMG_H);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

    logic              pix_en;
    logic [ADDR_W-1:0] row_base;

    logic              h_last;
    logic              v_last;
    logic [9:0]        h_nxt;
    logic [9:0]        v_nxt;
    logic [ADDR_W-1:0] rb_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              hsync_nxt;
    logic              vsync_nxt;
    logic              blank_nxt;

    always_comb begin
        h_last = (x == H_LAST);
        v_last = (y == V_LAST);
        h_nxt  = h_last ? 10'd0 : x + 10'd1;
        v_nxt  = y;
        rb_nxt = row_base;
        if (h_last) begin
            v_nxt = v_last ? 10'd0 : y + 10'd1;
            // row_base tracks y*IMG_W without a multiplier; it stops once past the image
            if (v_last)
                rb_nxt = '0;
            else if (y < IMG_H_C)
                rb_nxt = row_base + ROW_STEP;
        end
        addr_nxt = '0;
        if ((h_nxt < IMG_W_C) && (v_nxt < IMG_H_C))
            addr_nxt = rb_nxt + ADDR_W'(h_nxt);
        hsync_nxt = !((h_nxt >= HS_FIRST) && (h_nxt <= HS_LAST));
        vsync_nxt = !((v_nxt >= VS_FIRST) && (v_nxt <= VS_LAST));
        blank_nxt = (h_nxt < H_ACT) && (v_nxt < V_ACT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_en      <= 1'b0;
            x           <= '0;
            y           <= '0;
            row_base    <= '0;
            addr        <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            blank_n     <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            pix_en      <= ~pix_en;
            frame_start <= 1'b0;
            if (pix_en) begin
                x           <= h_nxt;
                y           <= v_nxt;
                row_base    <= rb_nxt;
                addr        <= addr_nxt;
                hsync       <= hsync_nxt;
                vsync       <= vsync_nxt;
                blank_n     <= blank_nxt;
                frame_start <= h_last && v_last;
            end
        end
    end

    assign vga_clk = pix_en;
    assign sync_n  = 1'b0;

endmodule

// File: tb/tb_vga_pixel_scan.sv
// Bench for vga_pixel_scan with a shrunken raster so whole frames fit in a short run.
module tb_vga_pixel_scan;

    localparam int HA = 40, HFP = 4, HS = 8, HBP = 6;
    localparam int VA = 30, VFP = 2, VS = 2, VBP = 3;
    localparam int IW = 10, IH = 8, AW = 14;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FR = HT * VT;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [9:0]    x, y;
    logic [AW-1:0] addr;
    logic          hsync, vsync, blank_n, sync_n, vga_clk, frame_start;
    logic [7:0]    ram_q;

    int tests = 0;
    int fails = 0;
    int n = 0;

    vga_pixel_scan #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .IMG_W(IW), .IMG_H(IH), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .addr(addr),
        .hsync(hsync), .vsync(vsync), .blank_n(blank_n), .sync_n(sync_n),
        .vga_clk(vga_clk), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Synchronous image RAM holding addr[7:0] at every location, 1-clk read latency
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ram_q <= 8'd0;
        else        ram_q <= addr[7:0];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s at edge %0d: observed %0d expected %0d", tag, n, obs, exp);
        end
    endtask

    task automatic check_reset_state();
        check("rst_x", 32'(x), 0);
        check("rst_y", 32'(y), 0);
        check("rst_addr", 32'(addr), 0);
        check("rst_hsync", 32'(hsync), 1);
        check("rst_vsync", 32'(vsync), 1);
        check("rst_blank_n", 32'(blank_n), 1);
        check("rst_sync_n", 32'(sync_n), 0);
        check("rst_vga_clk", 32'(vga_clk), 0);
        check("rst_frame_start", 32'(frame_start), 0);
    endtask

    // Expected outputs after n clk edges since reset release: pixel index = floor(n/2) mod frame
    task automatic check_model();
        int k, p, ex, ey, ea, efs;
        k  = n / 2;
        p  = k % FR;
        ex = p % HT;
        ey = p / HT;
        ea = (ex < IW && ey < IH) ? ey * IW + ex : 0;
        efs = ((n % 2) == 0 && k > 0 && p == 0) ? 1 : 0;
        check("x", 32'(x), ex);
        check("y", 32'(y), ey);
        check("addr", 32'(addr), ea);
        check("hsync", 32'(hsync), (ex >= HA + HFP && ex < HA + HFP + HS) ? 0 : 1);
        check("vsync", 32'(vsync), (ey >= VA + VFP && ey < VA + VFP + VS) ? 0 : 1);
        check("blank_n", 32'(blank_n), (ex < HA && ey < VA) ? 1 : 0);
        check("vga_clk", 32'(vga_clk), n % 2);
        check("frame_start", 32'(frame_start), efs);
        check("sync_n", 32'(sync_n), 0);
        if ((n % 2) == 1)
            check("ram_read", 32'(ram_q), ea & 8'hFF);
    endtask

    task automatic run_edges(input int len);
        for (int i = 0; i < len; i++) begin
            @(posedge clk);
            #1;
            n++;
            check_model();
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
    endtask

    initial begin
        if (IW > HA || IH > VA) begin
            $display("FAIL config: image %0dx%0d exceeds active area %0dx%0d", IW, IH, HA, VA);
            $fatal(1, "bad configuration");
        end

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();

        release_reset();
        run_edges(2 * 2 * FR + 200);

        // Random mid-scan aborts: reset must take effect without waiting for a clock edge
        for (int r = 0; r < 4; r++) begin
            run_edges($urandom_range(3000, 50));
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            check_reset_state();
            repeat ($urandom_range(3, 1)) @(posedge clk);
            #1;
            check_reset_state();
            release_reset();
        end
        run_edges(2 * HT * (IH + 2));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
